// File: rtl/apb_pkg.sv
// Shared constants, FSM encoding and address helper for the APB slave memory.
package apb_pkg;

    localparam int unsigned PSEL_W     = 3;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_ADDR_W = 32;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_WAIT  = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    // Byte address to word index; depth must be a power of two (<= 256).
    function automatic logic [7:0] word_index(input logic [31:0] addr,
                                              input int unsigned depth);
        return 8'((addr >> 2) & (depth - 1));
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// DEPTH x DATA_W word array: async clear, one write port, one registered read port.
module apb_slave_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       re_i,
    input  logic                       rzero_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_W-1:0]          rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // rzero_i lets the caller return zero for a rejected read without touching the array.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed register memory and fixed wait states.
// Define APB_SLAVE_RANGE_CHECK_EN to reject out-of-range addresses with pslverr.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int unsigned DATA_W      = APB_DATA_W,
    parameter int unsigned ADDR_W      = APB_ADDR_W,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SEL_IDX     = 0,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic [PSEL_W-1:0]   psel,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

`ifdef APB_SLAVE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q,   err_d;

    logic              sel;
    logic              addr_err;
    logic [IDX_W-1:0]  addr_idx;
    logic              rd_en;
    logic              wr_en;
    logic              unused_psel;

    assign sel         = psel[SEL_IDX];
    assign unused_psel = ^psel;
    assign addr_idx    = IDX_W'(word_index(32'(paddr), DEPTH));
    assign addr_err    = RANGE_EN && ((paddr >> (IDX_W + 2)) != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel && !penable) begin
                    idx_d   = addr_idx;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    err_d   = addr_err;
                    rd_en   = !pwrite;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_READY;
                end
            end
            ST_WAIT: begin
                if (sel && penable) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_READY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                // A dropped strobe here aborts: no pready, no commit.
                if (sel && penable) begin
                    pready  = 1'b1;
                    pslverr = RANGE_EN && err_q;
                    wr_en   = write_q && !(RANGE_EN && err_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    apb_slave_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk_i   (hclk),
        .rst_ni  (hresetn),
        .we_i    (wr_en),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .re_i    (rd_en),
        .rzero_i (addr_err),
        .raddr_i (addr_idx),
        .rdata_o (prdata)
    );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Two slaves on one APB bus (zero-wait on psel[0], three waits on psel[1]) against an array model.
module tb_apb_slave_mem;

`ifdef APB_SLAVE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        hclk;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_m   [2][16];
    logic [31:0] last_rd [2];

    apb_slave_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(16), .SEL_IDX(0), .WAIT_CYCLES(0)
    ) dut0 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_mem #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(16), .SEL_IDX(1), .WAIT_CYCLES(3)
    ) dut1 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            last_rd[s] = 32'h0;
            for (int w = 0; w < 16; w++) mem_m[s][w] = 32'h0;
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the completing edge.
    task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int          lat;
        int          exp_lat;
        int          idx;
        bit          err_exp;
        logic        rdy, err, other_rdy;
        logic [31:0] rd, exp_rd;
        exp_lat = (s == 0) ? 1 : 4;
        idx     = int'((addr / 4) % 16);
        err_exp = RANGE_EN && (addr >= 32'h40);
        psel    = (s == 0) ? 3'b001 : 3'b010;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wd;
        @(posedge hclk); #1;
        penable = 1'b1;
        paddr   = $urandom;
        pwdata  = $urandom;
        lat = 0;
        while (1) begin
            @(negedge hclk);
            lat++;
            rdy       = (s == 0) ? pready0  : pready1;
            err       = (s == 0) ? pslverr0 : pslverr1;
            rd        = (s == 0) ? prdata0  : prdata1;
            other_rdy = (s == 0) ? pready1  : pready0;
            if (rdy || lat >= exp_lat + 4) break;
            @(posedge hclk); #1;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("other_pready", {31'b0, other_rdy}, 32'h0);
        check_eq("pslverr", {31'b0, err}, {31'b0, err_exp});
        if (wr) begin
            if (!err_exp) mem_m[s][idx] = wd;
            exp_rd = last_rd[s];
            check_eq("prdata_hold_on_write", rd, exp_rd);
        end else begin
            exp_rd = err_exp ? 32'h0 : mem_m[s][idx];
            last_rd[s] = exp_rd;
            check_eq("read_data", rd, exp_rd);
        end
        @(posedge hclk); #1;
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    task automatic abort_write(input logic [31:0] addr, input logic [31:0] wd);
        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = addr;
        pwdata  = wd;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(negedge hclk);
        check_eq("abort_pready_wait", {31'b0, pready1}, 32'h0);
        @(posedge hclk); #1;
        penable = 1'b0;
        @(negedge hclk);
        check_eq("abort_pready_drop", {31'b0, pready1}, 32'h0);
        @(posedge hclk); #1;
        psel = 3'b000;
        @(posedge hclk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        clear_model();
        hresetn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 32'h0;
        pwdata  = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        check_eq("rst_prdata0",  prdata0, 32'h0);
        check_eq("rst_pready0",  {31'b0, pready0}, 32'h0);
        check_eq("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
        check_eq("rst_prdata1",  prdata1, 32'h0);
        check_eq("rst_pready1",  {31'b0, pready1}, 32'h0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h8, 32'h0);

        xfer(1, 1'b1, 32'h4, 32'h12345678);
        xfer(1, 1'b0, 32'h4, 32'h0);

        xfer(1, 1'b1, 32'h0, 32'h0000FFFF);
        xfer(0, 1'b0, 32'h0, 32'h0);

        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 32'(i * 4), 32'(16 + i));
        for (int i = 0; i < 4; i++) xfer(0, 1'b0, 32'(i * 4), 32'h0);

        abort_write(32'h4, 32'hAA);
        xfer(1, 1'b0, 32'h4, 32'h0);

        xfer(0, 1'b1, 32'h40, 32'h55);
        xfer(0, 1'b0, 32'h0, 32'h0);
        xfer(0, 1'b0, 32'h40, 32'h0);

        for (int i = 0; i < 200; i++) begin
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3)), $urandom);
        end

        psel    = 3'b010;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'hCAFEF00D;
        @(posedge hclk); #1;
        penable = 1'b1;
        @(posedge hclk); #1;
        hresetn = 1'b0;
        #1;
        check_eq("midrst_pready1",  {31'b0, pready1}, 32'h0);
        check_eq("midrst_pslverr1", {31'b0, pslverr1}, 32'h0);
        check_eq("midrst_prdata0",  prdata0, 32'h0);
        check_eq("midrst_prdata1",  prdata1, 32'h0);
        psel    = 3'b000;
        penable = 1'b0;
        clear_model();
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) xfer(s, 1'b0, 32'(w * 4), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB responder (completer) that terminates the bridge's APB master side: word-addressed register memory with configurable wait states.
- Decodes one bit of the bridge's psel bus, accepts setup/access phases, and commits writes or returns read data.
- Replaces the pass-through APB interface as the real slave model in system benches, and is usable as a simple peripheral register bank.

Parameters:
- DATA_W, 32, width of pwdata/prdata.
- ADDR_W, 32, width of paddr.
- DEPTH, 16, number of DATA_W words; power of two, 2..256.
- SEL_IDX, 0, index of the psel bit that selects this slave (0..2).
- WAIT_CYCLES, 0, wait states inserted in every access phase (0..15); 0 is the zero-wait transfer.

Ports:
- hclk  in  1  system clock, rising-edge.
- hresetn  in  1  asynchronous active-low reset.
- psel  in  3  APB slave selects from the bridge; only psel[SEL_IDX] is used.
- penable  in  1  APB access-phase strobe.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address; word index = paddr[log2(DEPTH)+1:2].
- pwdata  in  DATA_W  write data.
- prdata  out  DATA_W  read data, registered.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response, valid only while pready=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, prdata=0, pready=0, pslverr=0, wait counter=0, all DEPTH words cleared to 0.
- sel = psel[SEL_IDX].
- FSM states: IDLE, WAIT, READY.
- IDLE:
  - On sel=1 & penable=0 (setup phase), latch index, pwrite and pwdata.
  - On a read, also load prdata <= mem[index] at the same edge.
  - Load counter <= WAIT_CYCLES. Next state is WAIT if WAIT_CYCLES>0, else READY.
- WAIT: sel=1 & penable=1 decrements the counter; at counter 1, go to READY.
- READY:
  - pready=1 combinationally whenever state=READY & sel & penable.
  - A write commits mem[index] <= latched pwdata at the edge with pready=1.
  - Next state is IDLE. A back-to-back setup in the following cycle is handled normally from IDLE.
- Latency:
  - Zero-wait read: data on prdata from the first access cycle.
  - Access phase lasts WAIT_CYCLES+1 cycles.
- Outside READY, pready=0 and pslverr=0.
- prdata holds its last value between transfers. Writes never change prdata.
- Protocol violation (sel or penable drops during WAIT/READY before completion): abort, return to IDLE, no memory write, pready stays 0.
- paddr/pwdata changes during the access phase are ignored; the setup-phase values are used.
- paddr[1:0] is ignored; no byte lanes.
- Reset mid-transfer: immediate abort; memory cleared; no partial write.
- The current bridge does not sample pready; system benches use WAIT_CYCLES=0 with it.

Optional Feature:
- Macro APB_SLAVE_RANGE_CHECK_EN.
- Defined:
  - A transfer with paddr >= DEPTH*4 completes normally (same wait states) with pslverr=1 in the READY cycle.
  - Writes are suppressed; reads load prdata=0.
- Undefined:
  - Upper address bits are ignored, so the address wraps modulo DEPTH*4.
  - pslverr is tied to 0.

Decomposition:
- Package apb_pkg holds:
  - FSM state encoding (IDLE=2'b00, WAIT=2'b01, READY=2'b10).
  - PSEL_W=3.
  - Default DATA_W/ADDR_W constants.
  - Address-to-word-index function.
- One sub-module, apb_slave_regfile: DEPTH x DATA_W array with async clear, one write port, one registered read port.
- The FSM and counter stay in apb_slave_mem.

Test Plan:
- Zero-wait write then read, WAIT_CYCLES=0, psel=3'b001:
  - Write 0xDEADBEEF to paddr 0x8 -> pready=1 in the single access cycle.
  - Read 0x8 -> prdata=0xDEADBEEF in the access cycle.
- Wait states, WAIT_CYCLES=3:
  - Write 0x12345678 to 0x4 -> pready low for 3 access cycles, high on the 4th.
  - Read returns 0x12345678.
- Wrong select: psel=3'b010 while SEL_IDX=0, write 0xFFFF to 0x0 -> pready stays 0; subsequent read of 0x0 returns 0.
- Four back-to-back writes 0x10..0x13 to 0x0,0x4,0x8,0xC, then four reads -> prdata 0x10,0x11,0x12,0x13 in order; no idle cycles required between transfers.
- Abort and reset:
  - penable dropped in WAIT during a write of 0xAA to 0x4 -> no write; read of 0x4 returns prior value.
  - hresetn low mid-access -> prdata=0, pready=0, all words read back 0.
- With APB_SLAVE_RANGE_CHECK_EN, DEPTH=16:
  - Write to 0x40 -> pslverr=1 with pready; memory unchanged.
  - Read of 0x40 -> prdata=0, pslverr=1.
  - Without the macro, a write to 0x40 lands in word 0.
